// File: rtl/accumulator_array.sv
// Multi-channel conv accumulator: sums signed product bursts per channel, adds bias,
// rescales, optional ReLU, saturates to DATA_W. One output register with valid/ready.
module accumulator_lane #(
    parameter int DATA_W    = 8,
    parameter int IN_W      = 2*DATA_W,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en,
    input  logic              fin_en,
    input  logic [IN_W-1:0]   data,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    output logic [DATA_W-1:0] res,
    output logic              sat
);
    localparam int AW1 = ACC_W + 1;
    localparam int SW  = ACC_W + 2;
    localparam logic [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [SW-1:0] OMAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [ACC_W-1:0]     acc, acc_nxt;
    logic                 sticky, ovf;
    logic [AW1-1:0]       a1;
    logic signed [SW-1:0] acc_x, dat_x, bias_x, s, sh;
    logic [DATA_W-1:0]    res_nxt;
    logic                 osat;

    // Running sum: one guard bit detects overflow of the ACC_W range.
    always_comb begin
        a1      = {acc[ACC_W-1], acc} + {{(AW1-IN_W){data[IN_W-1]}}, data};
        ovf     = a1[ACC_W] != a1[ACC_W-1];
        acc_nxt = ovf ? (a1[ACC_W] ? AMIN : AMAX) : a1[ACC_W-1:0];
    end

    // Final beat: biased sum at ACC_W+2 bits cannot wrap, then floor-shift.
    always_comb begin
        acc_x   = {{2{acc[ACC_W-1]}}, acc};
        dat_x   = {{(SW-IN_W){data[IN_W-1]}}, data};
        bias_x  = {{(SW-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_BITS;
        s       = acc_x + dat_x + bias_x;
        sh      = s >>> FRAC_BITS;
        osat    = 1'b0;
        if (relu_en && sh < 0)
            sh = '0;
        if (sh > OMAX) begin
            res_nxt = OMAX[DATA_W-1:0];
            osat    = 1'b1;
        end else if (sh < OMIN) begin
            res_nxt = OMIN[DATA_W-1:0];
            osat    = 1'b1;
        end else begin
            res_nxt = sh[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            sticky <= 1'b0;
            res    <= '0;
            sat    <= 1'b0;
        end else if (acc_en) begin
            acc    <= acc_nxt;
            sticky <= sticky | ovf;
        end else if (fin_en) begin
            acc    <= '0;
            sticky <= 1'b0;
            res    <= res_nxt;
            sat    <= osat | sticky;
        end
    end
endmodule

module accumulator_array #(
    parameter int DATA_W    = 8,
    parameter int IN_W      = 2*DATA_W,
    parameter int CH        = 4,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [CH*IN_W-1:0]   in_data,
    input  logic [CH*DATA_W-1:0] in_bias,
    input  logic                 relu_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic [CH-1:0]        out_sat
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                       state_q, state_d;
    logic                         beat, acc_en, fin_en;
    logic [CH-1:0][IN_W-1:0]      dat;
    logic [CH-1:0][DATA_W-1:0]    bias, res;

    assign dat      = in_data;
    assign bias     = in_bias;
    assign out_data = res;

    // Ready never looks at in_valid/in_last so upstream can't form a loop through it.
    assign in_ready = ena && (!out_valid || out_ready);
    assign beat     = in_valid && in_ready;
    assign acc_en   = beat && !in_last;
    assign fin_en   = beat && in_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_en) state_d = ACCUM;
            ACCUM:   if (fin_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A last beat accepted in the transfer cycle replaces the result without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            out_valid <= 1'b0;
        else if (fin_en)
            out_valid <= 1'b1;
        else if (ena && out_valid && out_ready)
            out_valid <= 1'b0;
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        accumulator_lane #(
            .DATA_W(DATA_W), .IN_W(IN_W), .ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .clk(clk), .rst(rst), .acc_en(acc_en), .fin_en(fin_en),
            .data(dat[c]), .bias(bias[c]), .relu_en(relu_en),
            .res(res[c]), .sat(out_sat[c])
        );
    end
endmodule

// File: tb/tb_accumulator_array.sv
// Bench for accumulator_array: vector table through a scoreboard, plus hand-written
// backpressure, async reset and FRAC_BITS/ena corner sequences.
module tb_accumulator_array;
    localparam int CH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ena, in_valid, in_ready, in_last, relu_en, out_valid, out_ready;
    logic [63:0] in_data;
    logic [31:0] in_bias, out_data;
    logic [3:0]  out_sat;
    logic        ena1, in_valid1, in_ready1, in_last1, relu_en1, out_valid1, out_ready1;
    logic [63:0] in_data1;
    logic [31:0] in_bias1, out_data1;
    logic [3:0]  out_sat1;

    accumulator_array #(.DATA_W(8), .CH(CH), .ACC_W(32), .FRAC_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_data(in_data), .in_bias(in_bias), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat));

    accumulator_array #(.DATA_W(8), .CH(CH), .ACC_W(32), .FRAC_BITS(4)) dut1 (
        .clk(clk), .rst(rst), .ena(ena1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_last(in_last1), .in_data(in_data1), .in_bias(in_bias1), .relu_en(relu_en1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_sat(out_sat1));

    typedef struct packed { logic [31:0] d; logic [3:0] s; } res_t;
    typedef struct {
        int              n;
        logic [2:0][63:0] d;
        logic [31:0]     b;
        logic            r;
        logic [31:0]     e;
        logic [3:0]      s;
    } vec_t;

    res_t q0[$], q1[$];
    res_t e0, e1;
    int   n_chk = 0, n_fail = 0;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk16(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [31:0] pk8(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    always @(negedge clk) begin
        if (rst && ena && out_valid && out_ready) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb0_unexpected: got %h expected no result", out_data);
            end else begin
                e0 = q0.pop_front();
                chk("sb0_data", {32'd0, out_data}, {32'd0, e0.d});
                chk("sb0_sat", {60'd0, out_sat}, {60'd0, e0.s});
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ena1 && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb1_unexpected: got %h expected no result", out_data1);
            end else begin
                e1 = q1.pop_front();
                chk("sb1_data", {32'd0, out_data1}, {32'd0, e1.d});
                chk("sb1_sat", {60'd0, out_sat1}, {60'd0, e1.s});
            end
        end
    end

    // Drives one beat on dut0 (called at posedge+1), waits for ready, pushes the expectation.
    task automatic beat(input logic [63:0] d, input logic last, input logic [31:0] b,
                        input logic r, input logic push, input res_t e);
        int k;
        in_data = d; in_last = last; in_bias = b; relu_en = r; in_valid = 1'b1;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL beat_timeout: got in_ready 0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        if (last && push) q0.push_back(e);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        vecs[0] = '{n:2, d:{64'd0, pk16(7,0,0,0), pk16(3,0,0,0)}, b:pk8(2,0,0,0), r:1'b0,
                    e:pk8(12,0,0,0), s:4'b0000};
        vecs[1] = '{n:2, d:{64'd0, pk16(100,-100,0,0), pk16(100,-100,0,0)}, b:pk8(0,0,0,0), r:1'b0,
                    e:pk8(127,-128,0,0), s:4'b0011};
        vecs[2] = '{n:1, d:{64'd0, 64'd0, pk16(-5,0,0,0)}, b:pk8(2,0,0,0), r:1'b1,
                    e:pk8(0,0,0,0), s:4'b0000};
        vecs[3] = '{n:1, d:{64'd0, 64'd0, pk16(-5,0,0,0)}, b:pk8(2,0,0,0), r:1'b0,
                    e:pk8(-3,0,0,0), s:4'b0000};
        vecs[4] = '{n:1, d:{64'd0, 64'd0, pk16(-200,127,128,-129)}, b:pk8(100,0,0,0), r:1'b0,
                    e:pk8(-100,127,127,-128), s:4'b1100};
        vecs[5] = '{n:3, d:{pk16(-5,-20,5,-20), pk16(20,-60,-30000,-60), pk16(10,-50,30000,-50)},
                    b:pk8(-3,5,0,5), r:1'b0, e:pk8(22,-125,5,-125), s:4'b0000};
        vecs[6] = '{n:3, d:{pk16(-5,-20,5,-20), pk16(20,-60,-30000,-60), pk16(10,-50,30000,-50)},
                    b:pk8(-3,5,0,5), r:1'b1, e:pk8(22,0,5,0), s:4'b0000};

        rst = 1'b0;
        ena = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bias = '0;
        relu_en = 1'b0; out_ready = 1'b1;
        ena1 = 1'b1; in_valid1 = 1'b0; in_last1 = 1'b0; in_data1 = '0; in_bias1 = '0;
        relu_en1 = 1'b0; out_ready1 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_sat", {60'd0, out_sat}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++)
            for (int b = 0; b < vecs[v].n; b++)
                beat(vecs[v].d[b], b == vecs[v].n - 1, vecs[v].b, vecs[v].r, 1'b1,
                     res_t'{vecs[v].e, vecs[v].s});
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: stalled result blocks input, then releases with a same-cycle last beat.
        out_ready = 1'b0;
        beat(pk16(9,0,0,0), 1'b1, 32'd0, 1'b0, 1'b1, res_t'{pk8(9,0,0,0), 4'b0});
        in_valid = 1'b1; in_data = pk16(50,0,0,0); in_last = 1'b1; in_bias = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_out_stable", {32'd0, out_data}, {32'd0, pk8(9,0,0,0)});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        q0.push_back(res_t'{pk8(50,0,0,0), 4'b0});
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_b2b_data", {32'd0, out_data}, {32'd0, pk8(50,0,0,0)});
        @(posedge clk); #1;
        chk("bp_drain_valid", {63'd0, out_valid}, 64'd0);

        // Async reset with a pending result, then with a partial sum.
        out_ready = 1'b0;
        beat(pk16(33,0,0,0), 1'b1, 32'd0, 1'b0, 1'b0, res_t'{32'd0, 4'b0});
        #1 rst = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_data", {32'd0, out_data}, 64'd0);
        chk("arst_out_sat", {60'd0, out_sat}, 64'd0);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        beat(pk16(10,0,0,0), 1'b0, 32'd0, 1'b0, 1'b1, res_t'{32'd0, 4'b0});
        beat(pk16(20,0,0,0), 1'b0, 32'd0, 1'b0, 1'b1, res_t'{32'd0, 4'b0});
        #1 rst = 1'b0;
        #1;
        chk("arst2_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst2_out_data", {32'd0, out_data}, 64'd0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        beat(pk16(5,0,0,0), 1'b1, pk8(1,0,0,0), 1'b0, 1'b1, res_t'{pk8(6,0,0,0), 4'b0});
        repeat (2) @(posedge clk);
        #1;

        // FRAC_BITS=4 instance: floor shift, then ena low freezes everything.
        in_valid1 = 1'b1; in_data1 = pk16(48,0,0,-40); in_last1 = 1'b0; in_bias1 = pk8(2,0,0,0);
        @(negedge clk);
        chk("f4_ready_b0", {63'd0, in_ready1}, 64'd1);
        @(posedge clk); #1;
        in_data1 = pk16(16,-1,40,0); in_last1 = 1'b1;
        @(negedge clk);
        chk("f4_ready_b1", {63'd0, in_ready1}, 64'd1);
        @(posedge clk);
        q1.push_back(res_t'{pk8(6,-1,2,-3), 4'b0});
        #1;
        ena1 = 1'b0; in_data1 = pk16(160,0,0,0); in_last1 = 1'b0; in_bias1 = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ena_in_ready", {63'd0, in_ready1}, 64'd0);
            chk("ena_out_valid", {63'd0, out_valid1}, 64'd1);
            chk("ena_out_data", {32'd0, out_data1}, {32'd0, pk8(6,-1,2,-3)});
            @(posedge clk); #1;
        end
        ena1 = 1'b1; in_valid1 = 1'b0;
        @(posedge clk); #1;
        chk("ena_drain_valid", {63'd0, out_valid1}, 64'd0);
        in_valid1 = 1'b1; in_data1 = pk16(16,0,0,0); in_last1 = 1'b1;
        @(negedge clk);
        chk("f4_ready_single", {63'd0, in_ready1}, 64'd1);
        @(posedge clk);
        q1.push_back(res_t'{pk8(1,0,0,0), 4'b0});
        #1;
        in_valid1 = 1'b0; in_last1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb0_empty", 64'(q0.size()), 64'd0);
        chk("sb1_empty", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
